fp_addsub_arbiter: RTL and testbench

FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

---
 rtl/fp_addsub_arbiter.sv | 172 +++++++++++++++++
 tb/tb_fp_addsub_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fp_addsub_arbiter (with shared add/sub unit Final)
//  Purpose  : Round-robin sharing of one single-precision add/sub unit
//             between two requesters.
//  Revision : 1.0  initial release
// ============================================================================

// Combinational single-precision add/sub. Truncating; Inf/NaN operands are
// not special-cased.
module Final (
   input  logic [31:0] NumberA,
   input  logic [31:0] NumberB,
   input  logic        A_S,
   output logic [31:0] Result
);
   logic        w_sa, w_sb, w_sx, w_sy, w_swap, w_eff_sub;
   logic [7:0]  w_ea, w_eb, w_ex, w_ey, w_d, w_sh;
   logic [26:0] w_ma, w_mb, w_mx, w_my, w_my_sh;
   logic [27:0] w_sum, w_norm;
   logic [4:0]  w_lz;
   logic [9:0]  w_e_res;
   logic        w_unused;

   always_comb begin
      w_sa = NumberA[31];
      w_sb = NumberB[31] ^ A_S;
      // Denormals share the exponent scale of exponent 1 with no hidden bit
      w_ea = (NumberA[30:23] == 8'd0) ? 8'd1 : NumberA[30:23];
      w_eb = (NumberB[30:23] == 8'd0) ? 8'd1 : NumberB[30:23];
      w_ma = {|NumberA[30:23], NumberA[22:0], 3'b000};
      w_mb = {|NumberB[30:23], NumberB[22:0], 3'b000};
      w_swap = {w_eb, w_mb} > {w_ea, w_ma};
      w_sx = w_swap ? w_sb : w_sa;
      w_sy = w_swap ? w_sa : w_sb;
      w_ex = w_swap ? w_eb : w_ea;
      w_ey = w_swap ? w_ea : w_eb;
      w_mx = w_swap ? w_mb : w_ma;
      w_my = w_swap ? w_ma : w_mb;
      w_eff_sub = w_sx ^ w_sy;
      w_d = w_ex - w_ey;
      w_my_sh = (w_d > 8'd26) ? 27'd0 : (w_my >> w_d);
      w_sum = w_eff_sub ? ({1'b0, w_mx} - {1'b0, w_my_sh})
                        : ({1'b0, w_mx} + {1'b0, w_my_sh});
      w_lz = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (w_sum[i]) w_lz = 5'(26 - i);
      end
      w_sh = 8'd0;
      if (w_sum[27]) begin
         w_e_res = {2'b00, w_ex} + 10'd1;
         w_norm  = w_sum >> 1;
      end else if ({3'b000, w_lz} < w_ex) begin
         w_e_res = {2'b00, w_ex} - {5'd0, w_lz};
         w_norm  = w_sum << w_lz;
      end else begin
         // Result underflows into the denormal range
         w_sh    = w_ex - 8'd1;
         w_e_res = 10'd0;
         w_norm  = w_sum << w_sh;
      end
      if (w_sum == 28'd0)
         Result = 32'h0000_0000;
      else if (w_e_res >= 10'd255)
         Result = {w_sx, 8'hFF, 23'd0};
      else
         Result = {w_sx, w_e_res[7:0], w_norm[25:3]};
   end

   assign w_unused = &{1'b0, w_norm[27:26], w_norm[2:0]};
endmodule

module fp_addsub_arbiter #(
   parameter int FIRST_PRIO = 0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic             req0_op,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic             req1_op,
   output logic             req1_ready,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [31:0]      rsp_result,
   input  logic             rsp_ready,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic c_last_rst = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

   state_t            r_state, w_next;
   logic              r_last, r_id, r_op;
   logic [31:0]       r_a, r_b, r_result;
   logic [CNT_W-1:0]  r_count;
   logic              w_accept, w_pick;
   logic [31:0]       w_fp_result;

   Final u_fp (
      .NumberA (r_a),
      .NumberB (r_b),
      .A_S     (r_op),
      .Result  (w_fp_result)
   );

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      // Under contention the requester not granted last time wins
      w_pick = (req0_valid && req1_valid) ? ~r_last : req1_valid;
      case (r_state)
         IDLE: begin
            if (!rst && (req0_valid || req1_valid)) begin
               w_accept   = 1'b1;
               req0_ready = ~w_pick;
               req1_ready = w_pick;
               w_next     = EXEC;
            end
         end
         EXEC:    w_next = RESP;
         RESP:    if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_last   <= c_last_rst;
         r_id     <= 1'b0;
         r_op     <= 1'b0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_result <= 32'd0;
         r_count  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_last <= w_pick;
            r_id   <= w_pick;
            r_a    <= w_pick ? req1_a  : req0_a;
            r_b    <= w_pick ? req1_b  : req0_b;
            r_op   <= w_pick ? req1_op : req0_op;
         end
         if (r_state == EXEC)
            r_result <= w_fp_result;
         if (r_state == RESP && rsp_ready && !(&r_count))
            r_count <= r_count + 1'b1;
      end
   end

   assign rsp_valid  = (r_state == RESP);
   assign rsp_id     = r_id;
   assign rsp_result = r_result;
   assign busy       = (r_state != IDLE);
   assign op_count   = r_count;
endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_addsub_arbiter
//  Purpose  : Randomized self-checking bench against an integer-arithmetic
//             reference model of the arbitrated add/sub block.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_addsub_arbiter;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_op, req0_ready;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_op, req1_ready;
   logic [31:0] req1_a, req1_b;
   logic        rsp_valid, rsp_id, rsp_ready, busy;
   logic [31:0] rsp_result;
   logic [CNT_W-1:0] op_count;

   int n_checks = 0;
   int n_pass   = 0;
   int m_count  = 0;
   bit m_last   = 1'b1;

   always #5 clk = ~clk;

   fp_addsub_arbiter #(.FIRST_PRIO(0), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .req1_ready (req1_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_ready  (rsp_ready),
      .busy       (busy),
      .op_count   (op_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Exact single-precision encoding of an integer below 2^24 in magnitude
   function automatic logic [31:0] fp_of_int(input int v);
      int     mag;
      int     p;
      longint m;
      if (v == 0) return 32'h0000_0000;
      mag = (v < 0) ? -v : v;
      p = 0;
      for (int i = 0; i < 31; i++) if (mag >= (1 << i)) p = i;
      m = longint'(mag) << (23 - p);
      return {(v < 0), 8'(127 + p), m[22:0]};
   endfunction

   function automatic int rnd_int();
      return int'($urandom_range(0, 1048575)) - 524288;
   endfunction

   task automatic scramble();
      req0_a = $urandom; req0_b = $urandom; req0_op = 1'($urandom_range(0, 1));
      req1_a = $urandom; req1_b = $urandom; req1_op = 1'($urandom_range(0, 1));
   endtask

   task automatic run_op(input bit v0, input bit v1,
                         input logic [31:0] a0, input logic [31:0] b0, input bit op0,
                         input logic [31:0] a1, input logic [31:0] b1, input bit op1,
                         input logic [31:0] exp0, input logic [31:0] exp1, input int hold);
      bit          win;
      logic [31:0] exp_res;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
      rsp_ready  = 1'b0;
      #1;
      win     = (v0 && v1) ? !m_last : v1;
      m_last  = win;
      exp_res = win ? exp1 : exp0;
      check("ready0_accept", req0_ready, !win);
      check("ready1_accept", req1_ready, win);
      check("busy_idle", busy, 1'b0);
      @(posedge clk); #1;
      // Operands change while the operation is in flight
      scramble();
      #1;
      check("ready0_exec", req0_ready, 1'b0);
      check("ready1_exec", req1_ready, 1'b0);
      check("busy_exec", busy, 1'b1);
      check("rsp_valid_exec", rsp_valid, 1'b0);
      @(posedge clk); #1;
      for (int c = 0; c <= hold; c++) begin
         check("rsp_valid", rsp_valid, 1'b1);
         check("rsp_id", rsp_id, win);
         check("rsp_result", rsp_result, exp_res);
         check("ready0_resp", req0_ready, 1'b0);
         check("ready1_resp", req1_ready, 1'b0);
         if (c == hold) rsp_ready = 1'b1;
         @(posedge clk); #1;
      end
      rsp_ready = 1'b0;
      m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
      check("rsp_done", rsp_valid, 1'b0);
      check("busy_done", busy, 1'b0);
      check("op_count", 32'(op_count), 32'(m_count));
   endtask

   task automatic rand_op(input bit v0, input bit v1, input int hold);
      int          a[2], b[2];
      bit          o[2];
      logic [31:0] e[2];
      for (int r = 0; r < 2; r++) begin
         a[r] = rnd_int();
         b[r] = rnd_int();
         o[r] = 1'($urandom_range(0, 1));
         e[r] = fp_of_int(o[r] ? a[r] - b[r] : a[r] + b[r]);
      end
      run_op(v0, v1, fp_of_int(a[0]), fp_of_int(b[0]), o[0],
             fp_of_int(a[1]), fp_of_int(b[1]), o[1], e[0], e[1], hold);
   endtask

   task automatic do_reset();
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      rst = 1'b1;
      #1;
      check("ready0_in_rst", req0_ready, 1'b0);
      check("ready1_in_rst", req1_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      m_count = 0;
      m_last  = 1'b1;
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_id", rsp_id, 1'b0);
      check("rst_rsp_result", rsp_result, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_op_count", 32'(op_count), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      scramble();
      @(posedge clk); #1;
      do_reset();

      run_op(1'b1, 1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0,
             32'h0, 32'h0, 1'b0, 32'h4040_0000, 32'h0, 0);
      run_op(1'b0, 1'b1, 32'h0, 32'h0, 1'b0,
             32'h3FC0_0000, 32'h3F00_0000, 1'b1, 32'h0, 32'h3F80_0000, 0);
      // Denormal results and denormal-to-normal carry pass through bit-exact
      run_op(1'b1, 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0,
             32'h0, 32'h0, 1'b0, 32'h0000_0002, 32'h0, 0);
      run_op(1'b0, 1'b1, 32'h0, 32'h0, 1'b0,
             32'h0040_0000, 32'h0040_0000, 1'b0, 32'h0, 32'h0080_0000, 1);

      do_reset();
      for (int k = 0; k < 4; k++) rand_op(1'b1, 1'b1, 0);

      rand_op(1'b1, 1'b0, 5);
      rand_op(1'b0, 1'b1, 0);

      // Reset while in EXEC drops the operation
      req0_valid = 1'b1; req1_valid = 1'b0;
      req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000; req0_op = 1'b0;
      @(posedge clk); #1;
      check("mid_busy", busy, 1'b1);
      do_reset();
      for (int k = 0; k < 3; k++) begin
         check("dropped_no_rsp", rsp_valid, 1'b0);
         @(posedge clk); #1;
      end

      for (int k = 0; k < 30; k++) begin
         int pat;
         pat = int'($urandom_range(1, 3));
         rand_op(pat[0], pat[1], int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
